wb_writer: RTL and testbench

WB_WRITER -- requirements
Module: wb_writer

---
 rtl/wb_writer_pkg.sv | 11 +
 rtl/wb_fifo.sv | 41 ++++
 rtl/wb_writer.sv | 75 +++++++
 tb/tb_wb_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_writer_pkg.sv
// wb_writer_pkg: shared widths, default depth and the register-file write-request record
package wb_writer_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry write-request FIFO (push/din in, pop/dout/empty/full out, async active-high reset)
module wb_fifo
  import wb_writer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t dout,
  output logic    empty,
  output logic    full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  wb_req_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
  end
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      if (do_pop) rd <= rd == AW'(DEPTH - 1) ? '0 : rd + AW'(1);
      if (do_push) wr <= wr == AW'(DEPTH - 1) ? '0 : wr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/wb_writer.sv
// wb_writer: registered regfile write port arbitrating pipeline writes over queued multicycle results, with per-register pending scoreboard
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_a3,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic [DATA_W-1:0] pipe_pc,
  input  logic              mdu_issue,
  input  logic [REG_W-1:0]  mdu_issue_a3,
  output logic              mdu_issue_ready,
  input  logic              mdu_valid,
  input  logic [REG_W-1:0]  mdu_a3,
  input  logic [DATA_W-1:0] mdu_wd,
  input  logic [DATA_W-1:0] mdu_pc,
  input  logic [REG_W-1:0]  q_a1,
  input  logic [REG_W-1:0]  q_a2,
  output logic              busy1,
  output logic              busy2,
  output logic              WE,
  output logic [REG_W-1:0]  A3,
  output logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] PC
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] inflight;
  logic [2:0] pend [32];
  wb_req_t head;
  logic empty, full, sel_pipe, pop, push, drop, iss_ok;
  always_comb begin
    sel_pipe = pipe_we && pipe_a3 != '0;
    pop = !sel_pipe && !empty;
    iss_ok = mdu_issue && mdu_issue_ready;
    push = mdu_valid && inflight != '0 && mdu_a3 != '0;
    drop = mdu_valid && inflight != '0 && mdu_a3 == '0;
  end
  assign mdu_issue_ready = inflight < CW'(DEPTH);
  assign busy1 = q_a1 != '0 && pend[q_a1] != '0;
  assign busy2 = q_a2 != '0 && pend[q_a2] != '0;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  ({mdu_a3, mdu_wd, mdu_pc}),
    .pop  (pop),
    .dout (head),
    .empty(empty),
    .full (full)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) inflight <= '0;
    else inflight <= inflight + CW'(iss_ok) - CW'(pop) - CW'(drop);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 32; i++) pend[i] <= '0;
    end else begin
      pend[0] <= '0;
      for (int i = 1; i < 32; i++)
        pend[i] <= pend[i] + 3'(iss_ok && mdu_issue_a3 == REG_W'(i)) - 3'(pop && head.a3 == REG_W'(i));
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      WE <= 1'b0;
      A3 <= '0;
      WD <= '0;
      PC <= '0;
    end else begin
      WE <= sel_pipe || pop;
      if (sel_pipe || pop) {A3, WD, PC} <= sel_pipe ? {pipe_a3, pipe_wd, pipe_pc} : head;
    end
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: randomized and directed checks of wb_writer against a queue-based reference model
module tb_wb_writer;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pipe_we;
  logic [4:0] pipe_a3;
  logic [31:0] pipe_wd, pipe_pc;
  logic mdu_issue;
  logic [4:0] mdu_issue_a3;
  logic mdu_issue_ready;
  logic mdu_valid;
  logic [4:0] mdu_a3;
  logic [31:0] mdu_wd, mdu_pc;
  logic [4:0] q_a1 = '0, q_a2 = '0;
  logic busy1, busy2;
  logic WE;
  logic [4:0] A3;
  logic [31:0] WD, PC;
  int n_vec = 0, n_bad = 0;
  int inflight;
  int pend [32];
  int qa [$];
  logic [31:0] qd [$], qp [$];
  int outq [$];
  logic ewe;
  logic [4:0] ea3;
  logic [31:0] ewd, epc;

  wb_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
    .mdu_issue(mdu_issue), .mdu_issue_a3(mdu_issue_a3), .mdu_issue_ready(mdu_issue_ready),
    .mdu_valid(mdu_valid), .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
    .q_a1(q_a1), .q_a2(q_a2), .busy1(busy1), .busy2(busy2),
    .WE(WE), .A3(A3), .WD(WD), .PC(PC)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    pipe_we = 0; pipe_a3 = 0; pipe_wd = 0; pipe_pc = 0;
    mdu_issue = 0; mdu_issue_a3 = 0;
    mdu_valid = 0; mdu_a3 = 0; mdu_wd = 0; mdu_pc = 0;
  endtask

  task automatic model_clear();
    inflight = 0;
    foreach (pend[i]) pend[i] = 0;
    qa.delete(); qd.delete(); qp.delete(); outq.delete();
    ewe = 0; ea3 = 0; ewd = 0; epc = 0;
  endtask

  task automatic cyc();
    int inf0;
    bit sel, popm, acc;
    @(negedge clk);
    chk("ready", mdu_issue_ready, inflight < DEPTH);
    chk("busy1", busy1, q_a1 != 0 && pend[q_a1] > 0);
    chk("busy2", busy2, q_a2 != 0 && pend[q_a2] > 0);
    chk("we", WE, ewe);
    chk("a3", A3, ea3);
    chk("wd", WD, ewd);
    chk("pc", PC, epc);
    inf0 = inflight;
    sel = pipe_we && pipe_a3 != 0;
    popm = !sel && qa.size() > 0;
    acc = mdu_issue && inf0 < DEPTH;
    ewe = sel || popm;
    if (sel) begin
      ea3 = pipe_a3; ewd = pipe_wd; epc = pipe_pc;
    end else if (popm) begin
      ea3 = 5'(qa.pop_front()); ewd = qd.pop_front(); epc = qp.pop_front();
      inflight--;
      pend[ea3]--;
    end
    if (acc) begin
      inflight++;
      pend[mdu_issue_a3]++;
      outq.push_back(int'(mdu_issue_a3));
    end
    if (mdu_valid && inf0 != 0) begin
      if (mdu_a3 == 0) inflight--;
      else begin
        qa.push_back(int'(mdu_a3)); qd.push_back(mdu_wd); qp.push_back(mdu_pc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    #1;
    chk("rst_we", WE, 0);
    chk("rst_a3", A3, 0);
    chk("rst_wd", WD, 0);
    chk("rst_pc", PC, 0);
    chk("rst_rdy", mdu_issue_ready, 1);
    model_clear();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    do_reset();
    // single pipeline write appears for exactly one cycle
    pipe_we = 1; pipe_a3 = 8; pipe_wd = 32'h1234; pipe_pc = 32'h400;
    cyc();
    chk("d38_we", WE, 1); chk("d38_a3", A3, 8); chk("d38_wd", WD, 32'h1234);
    idle();
    cyc();
    chk("d38_we_off", WE, 0); chk("d38_hold", WD, 32'h1234);
    // pipeline writes pre-empt a queued result
    do_reset();
    q_a1 = 9; mdu_issue = 1; mdu_issue_a3 = 9;
    cyc();
    idle();
    cyc();
    mdu_valid = 1; mdu_a3 = 9; mdu_wd = 32'h99; mdu_pc = 32'h900;
    pipe_we = 1; pipe_a3 = 5; pipe_wd = 32'h55; pipe_pc = 32'h500;
    cyc();
    chk("d39_n1_a3", A3, 5); chk("d39_n1_busy", busy1, 1);
    mdu_valid = 0;
    cyc();
    chk("d39_n2_a3", A3, 5); chk("d39_n2_busy", busy1, 1);
    pipe_we = 0;
    cyc();
    chk("d39_n3_we", WE, 1); chk("d39_n3_a3", A3, 9); chk("d39_n3_wd", WD, 32'h99);
    chk("d39_n3_busy", busy1, 0);
    // in-flight limit
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      mdu_issue = 1; mdu_issue_a3 = 5'(i);
      cyc();
    end
    chk("d40_full", mdu_issue_ready, 0);
    mdu_issue_a3 = 6; q_a1 = 6;
    cyc();
    chk("d40_ignored", busy1, 0); chk("d40_still_full", mdu_issue_ready, 0);
    idle();
    mdu_valid = 1; mdu_a3 = 1; mdu_wd = 32'h11;
    cyc();
    chk("d40_queued", mdu_issue_ready, 0);
    idle();
    cyc();
    chk("d40_ready", mdu_issue_ready, 1); chk("d40_we", WE, 1); chk("d40_a3", A3, 1);
    // same register reserved twice
    do_reset();
    q_a1 = 3; mdu_issue = 1; mdu_issue_a3 = 3;
    cyc();
    cyc();
    idle();
    mdu_valid = 1; mdu_a3 = 3; mdu_wd = 32'h31;
    cyc();
    idle();
    cyc();
    chk("d41_one_left", busy1, 1);
    mdu_valid = 1; mdu_a3 = 3; mdu_wd = 32'h32;
    cyc();
    chk("d41_queued", busy1, 1);
    idle();
    cyc();
    chk("d41_done", busy1, 0); chk("d41_wd", WD, 32'h32);
    // results for register 0 and pipeline writes to register 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mdu_issue = 1; mdu_issue_a3 = 0;
      cyc();
    end
    chk("d42_full", mdu_issue_ready, 0);
    idle();
    mdu_valid = 1; mdu_a3 = 0; mdu_wd = 32'hbad;
    cyc();
    chk("d42_drop_rdy", mdu_issue_ready, 1); chk("d42_drop_we", WE, 0);
    idle();
    mdu_issue = 1; mdu_issue_a3 = 7;
    cyc();
    idle();
    mdu_valid = 1; mdu_a3 = 7; mdu_wd = 32'h77;
    cyc();
    idle();
    pipe_we = 1; pipe_a3 = 0; pipe_wd = 32'hdead;
    cyc();
    chk("d42_drain_we", WE, 1); chk("d42_drain_a3", A3, 7); chk("d42_drain_wd", WD, 32'h77);
    // reset with three queued results
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      mdu_issue = 1; mdu_issue_a3 = 5'(i);
      cyc();
    end
    idle();
    pipe_we = 1; pipe_a3 = 20; pipe_wd = 32'h20;
    for (int i = 1; i <= 3; i++) begin
      mdu_valid = 1; mdu_a3 = 5'(i); mdu_wd = 32'(i);
      cyc();
    end
    chk("d37_pre_we", WE, 1);
    do_reset();
    for (int q = 0; q < 32; q++) begin
      q_a1 = 5'(q);
      #1;
      chk("d37_busy", busy1, 0);
    end
    q_a1 = 0;
    mdu_valid = 1; mdu_a3 = 2; mdu_wd = 32'h5a1e;
    cyc();
    idle();
    cyc();
    chk("d37_stale1", WE, 0);
    cyc();
    chk("d37_stale2", WE, 0);
    // randomized traffic with a mid-run reset
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      pipe_we = 1'($urandom_range(0, 1));
      pipe_a3 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_wd = $urandom; pipe_pc = $urandom;
      mdu_issue = $urandom_range(0, 2) == 0;
      mdu_issue_a3 = 5'($urandom_range(0, 7));
      mdu_valid = 0; mdu_a3 = 0; mdu_wd = $urandom; mdu_pc = $urandom;
      if (outq.size() > 0 && $urandom_range(0, 2) == 0) begin
        mdu_valid = 1;
        mdu_a3 = 5'(outq.pop_front());
      end
      q_a1 = 5'($urandom_range(0, 7));
      q_a2 = 5'($urandom_range(0, 7));
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
